// File: rtl/exec_writeback_if.sv
// Execute-to-writeback handshake bundle: ALU result in, register write out.
// The block holds the slave view; the execute stage / register file hold master.
interface exec_writeback_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_rd;
    logic [31:0] in_result;
    logic [3:0]  in_flags;
    logic        in_wr_rd;
    logic        in_set_flags;
    logic        wb_valid;
    logic        wb_ready;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;

    modport master (
        output in_valid, in_rd, in_result, in_flags, in_wr_rd, in_set_flags,
        input  in_ready,
        input  wb_valid, wb_rd, wb_data,
        output wb_ready
    );

    modport slave (
        input  in_valid, in_rd, in_result, in_flags, in_wr_rd, in_set_flags,
        output in_ready,
        output wb_valid, wb_rd, wb_data,
        input  wb_ready
    );
endinterface

// File: rtl/exec_writeback.sv
// Writeback buffer: in-order result FIFO, APSR flag commit, operand forwarding.
// Forwarding comparators are built only when EXEC_WB_FORWARD_EN is defined.
module exec_writeback #(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    exec_writeback_if.slave        io,
    output logic [3:0]             apsr_flags,
    input  logic [3:0]             fwd_rs,
    output logic                   fwd_hit,
    output logic [31:0]            fwd_data
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    localparam logic [1:0] S_EMPTY   = 2'd0;
    localparam logic [1:0] S_PARTIAL = 2'd1;
    localparam logic [1:0] S_FULL    = 2'd2;

    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [1:0]    state_q, state_d;
    logic [3:0]    flags_q, flags_d;
    logic [3:0]    rd_q   [DEPTH];
    logic [3:0]    rd_d   [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   data_d [DEPTH];
    logic          accept;
    logic          push;
    logic          pop;

    // Readiness looks only at occupancy, never at wb_ready.
    assign io.in_ready = (state_q != S_FULL);
    assign io.wb_valid = (state_q != S_EMPTY);
    assign io.wb_rd    = io.wb_valid ? rd_q[rptr_q] : 4'd0;
    assign io.wb_data  = io.wb_valid ? data_q[rptr_q] : 32'd0;
    assign apsr_flags  = flags_q;

    always_comb begin
        accept  = io.in_valid & io.in_ready;
        push    = accept & io.in_wr_rd;
        pop     = io.wb_valid & io.wb_ready;
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        cnt_d   = cnt_q;
        flags_d = flags_q;
        rd_d    = rd_q;
        data_d  = data_q;
        state_d = S_PARTIAL;
        if (push) begin
            rd_d[wptr_q]   = io.in_rd;
            data_d[wptr_q] = io.in_result;
            wptr_d         = wptr_q + AW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
        if (accept & io.in_set_flags) begin
            flags_d = io.in_flags;
        end
        if (cnt_d == '0) begin
            state_d = S_EMPTY;
        end else if (cnt_d == DEPTH_C) begin
            state_d = S_FULL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            cnt_q   <= '0;
            state_q <= S_EMPTY;
            flags_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

    // Entry storage needs no reset: occupancy alone decides validity.
    always_ff @(posedge clk) begin
        rd_q   <= rd_d;
        data_q <= data_d;
    end

`ifdef EXEC_WB_FORWARD_EN
    logic [AW-1:0] fwd_idx;

    // Walk oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = rptr_q + AW'(i);
            if (((AW+1)'(i) < cnt_q) && (rd_q[fwd_idx] == fwd_rs)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[fwd_idx];
            end
        end
    end
`else
    logic unused_fwd_rs;
    assign unused_fwd_rs = ^fwd_rs;
    assign fwd_hit       = 1'b0;
    assign fwd_data      = '0;
`endif
endmodule

// File: tb/tb_exec_writeback.sv
// Bench for exec_writeback: queue-based reference model plus directed vectors.
// Build with or without EXEC_WB_FORWARD_EN; expectations follow the macro.
module tb_exec_writeback;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [3:0]  rd;
        logic [31:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  apsr_flags;
    logic [3:0]  fwd_rs;
    logic        fwd_hit;
    logic [31:0] fwd_data;

    int nchk = 0;
    int nerr = 0;

    ent_t        mq[$];
    logic [3:0]  mflags;
    bit          started = 0;
    logic [31:0] pop_log[$];

    exec_writeback_if io();

    exec_writeback #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .io         (io),
        .apsr_flags (apsr_flags),
        .fwd_rs     (fwd_rs),
        .fwd_hit    (fwd_hit),
        .fwd_data   (fwd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_fwd(input logic [3:0] rs, output logic hit, output logic [31:0] d);
        hit = 1'b0;
        d   = '0;
`ifdef EXEC_WB_FORWARD_EN
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].rd == rs) begin
                hit = 1'b1;
                d   = mq[i].d;
                break;
            end
        end
`endif
    endfunction

    // Reference model: a FIFO of pending writes and a flags register.
    always @(posedge clk) begin : model
        bit acc;
        bit pp;
        started = 1;
        if (rst) begin
            mq.delete();
            mflags = '0;
        end else begin
            acc = io.in_valid && (mq.size() < DEPTH);
            pp  = io.wb_ready && (mq.size() > 0);
            if (pp) void'(mq.pop_front());
            if (acc && io.in_wr_rd) mq.push_back('{rd: io.in_rd, d: io.in_result});
            if (acc && io.in_set_flags) mflags = io.in_flags;
        end
    end

    always @(negedge clk) begin : compare
        logic        eh;
        logic [31:0] ed;
        if (started && !rst) begin
            chk("in_ready", io.in_ready, (mq.size() < DEPTH));
            chk("wb_valid", io.wb_valid, (mq.size() > 0));
            chk("wb_rd", io.wb_rd, (mq.size() > 0) ? mq[0].rd : 4'd0);
            chk("wb_data", io.wb_data, (mq.size() > 0) ? mq[0].d : 32'd0);
            chk("apsr_flags", apsr_flags, mflags);
            model_fwd(fwd_rs, eh, ed);
            chk("fwd_hit", fwd_hit, eh);
            chk("fwd_data", fwd_data, ed);
            if (io.wb_valid && io.wb_ready) pop_log.push_back(io.wb_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] rd, input logic [31:0] d, input logic wr,
                        input logic sf, input logic [3:0] fl);
        io.in_valid     = 1'b1;
        io.in_rd        = rd;
        io.in_result    = d;
        io.in_wr_rd     = wr;
        io.in_set_flags = sf;
        io.in_flags     = fl;
    endtask

    task automatic idle();
        io.in_valid     = 1'b0;
        io.in_wr_rd     = 1'b0;
        io.in_set_flags = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        bit ok;
        logic exp_hit;
        logic [31:0] exp_fd;
        rst = 1'b1;
        io.in_valid = 0; io.in_rd = 0; io.in_result = 0; io.in_flags = 0;
        io.in_wr_rd = 0; io.in_set_flags = 0; io.wb_ready = 0; fwd_rs = 0;
        tick(); tick();
        @(negedge clk);
        chk("rst_wb_valid", io.wb_valid, 0);
        chk("rst_in_ready", io.in_ready, 1);
        chk("rst_apsr", apsr_flags, 0);
        chk("rst_fwd_hit", fwd_hit, 0);
        tick();
        rst = 1'b0;

        // single write, one-cycle latency
        io.wb_ready = 1'b1;
        send(4'd3, 32'hAA, 1, 0, 4'd0);
        tick(); idle();
        @(negedge clk);
        chk("lat_wb_valid", io.wb_valid, 1);
        chk("lat_wb_rd", io.wb_rd, 3);
        chk("lat_wb_data", io.wb_data, 32'hAA);
        tick();
        @(negedge clk);
        chk("lat_drained", io.wb_valid, 0);

        // fill, back-pressure, drain in order
        pop_log.delete();
        io.wb_ready = 1'b0;
        tick(); send(4'd1, 32'h11, 1, 0, 4'd0);
        tick(); send(4'd2, 32'h22, 1, 0, 4'd0);
        tick(); send(4'd4, 32'h33, 1, 0, 4'd0);
        @(negedge clk);
        chk("full_in_ready", io.in_ready, 0);
        tick(); tick();
        @(negedge clk);
        chk("full_hold_ready", io.in_ready, 0);
        chk("full_head", io.wb_data, 32'h11);
        tick();
        io.wb_ready = 1'b1;
        ok = 0;
        for (int k = 0; k < 10 && !ok; k++) begin
            @(negedge clk);
            acc = io.in_ready;
            tick();
            if (acc) begin
                idle();
                ok = 1;
            end
        end
        chk("third_accept_timeout", ok, 1);
        for (int k = 0; k < 10 && pop_log.size() < 3; k++) tick();
        chk("drain_count", pop_log.size(), 3);
        if (pop_log.size() >= 3) begin
            chk("drain_0", pop_log[0], 32'h11);
            chk("drain_1", pop_log[1], 32'h22);
            chk("drain_2", pop_log[2], 32'h33);
        end

        // flag-only op
        send(4'd0, 32'd0, 0, 1, 4'b0110);
        tick(); idle();
        @(negedge clk);
        chk("flag_apsr", apsr_flags, 4'b0110);
        chk("flag_no_wb", io.wb_valid, 0);

        // forwarding picks the youngest of two matches
        tick();
        io.wb_ready = 1'b0;
        send(4'd5, 32'h10, 1, 0, 4'd0);
        tick(); send(4'd5, 32'h20, 1, 1, 4'b1000);
        tick(); idle(); fwd_rs = 4'd5;
`ifdef EXEC_WB_FORWARD_EN
        exp_hit = 1'b1; exp_fd = 32'h20;
`else
        exp_hit = 1'b0; exp_fd = 32'h0;
`endif
        @(negedge clk);
        chk("fwd_young_hit", fwd_hit, exp_hit);
        chk("fwd_young_data", fwd_data, exp_fd);
        chk("full_apsr", apsr_flags, 4'b1000);
        chk("full2_in_ready", io.in_ready, 0);
        fwd_rs = 4'd6;
        #1;
        chk("fwd_miss_hit", fwd_hit, 0);
        chk("fwd_miss_data", fwd_data, 0);
        fwd_rs = 4'd5;

        // reset while full, with an accept and pop attempted
        pop_log.delete();
        tick();
        rst = 1'b1;
        io.wb_ready = 1'b1;
        send(4'd9, 32'h99, 1, 1, 4'b1111);
        tick();
        rst = 1'b0;
        idle();
        @(negedge clk);
        chk("mrst_wb_valid", io.wb_valid, 0);
        chk("mrst_apsr", apsr_flags, 0);
        chk("mrst_in_ready", io.in_ready, 1);
        chk("mrst_fwd_hit", fwd_hit, 0);
        repeat (4) tick();
        chk("mrst_no_stale", pop_log.size(), 0);

        // steady push+pop at count 1 across pointer wrap
        pop_log.delete();
        send(4'd1, 32'd1, 1, 0, 4'd0);
        tick();
        for (int k = 2; k <= 9; k++) begin
            send(4'(k), 32'(k), 1, 0, 4'd0);
            @(negedge clk);
            chk("ss_in_ready", io.in_ready, 1);
            chk("ss_head", io.wb_data, 32'(k - 1));
            tick();
        end
        idle();
        @(negedge clk);
        chk("ss_last", io.wb_data, 32'd9);
        tick();
        @(negedge clk);
        chk("ss_empty", io.wb_valid, 0);
        chk("ss_pops", pop_log.size(), 9);
        for (int k = 0; k < 9 && k < pop_log.size(); k++)
            chk("ss_order", pop_log[k], 32'(k + 1));
        tick();

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/exec_writeback.md
EXEC_WRITEBACK -- requirements
Module: exec_writeback

Interface
REQ-001 Parameter: DEPTH, 2, number of writeback buffer entries; power of two, >= 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  execute stage presents an ALU result this cycle.
REQ-005 in_ready  output  1  block accepts the presented result.
REQ-006 in_rd  input  4  destination register index.
REQ-007 in_result  input  32  ALU result.
REQ-008 in_flags  input  4  ALU flag_q {N,Z,C,V}.
REQ-009 in_wr_rd  input  1  result is written to in_rd; 0 for flag-only ops (CMP/CMN/TST).
REQ-010 in_set_flags  input  1  commit in_flags to APSR.
REQ-011 apsr_flags  output  4  committed {N,Z,C,V}; drives the ALU flag input.
REQ-012 wb_valid  output  1  buffered register write is available.
REQ-013 wb_ready  input  1  register file write port accepts it.
REQ-014 wb_rd  output  4  head entry destination index.
REQ-015 wb_data  output  32  head entry data.
REQ-016 fwd_rs  input  4  source register queried by decode.
REQ-017 fwd_hit  output  1  a buffered entry targets fwd_rs.
REQ-018 fwd_data  output  32  data of matching entry.

Function
REQ-019 Accept = in_valid & in_ready; write-pop = wb_valid & wb_ready.
REQ-020 in_ready SHALL be 1 iff count < DEPTH; it SHALL NOT depend on wb_ready (no full-buffer pass-through).
REQ-021 On accept with in_wr_rd=1, {in_rd,in_result} SHALL be pushed at the tail of an in-order FIFO; with in_wr_rd=0, nothing is pushed.
REQ-022 On accept with in_set_flags=1, apsr_flags SHALL equal in_flags from the next cycle, independent of FIFO state; otherwise apsr_flags holds.
REQ-023 wb_valid SHALL be 1 iff count > 0; wb_rd/wb_data SHALL present the oldest entry, 0 when empty.
REQ-024 Write-pop SHALL remove the head entry; latency from accept to wb_valid on an empty buffer is exactly 1 cycle.
REQ-025 Simultaneous push and pop SHALL leave count unchanged and preserve order; push when full cannot occur (in_ready=0).
REQ-026 Read/write pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-027 States: EMPTY (count=0), PARTIAL (0<count<DEPTH), FULL (count=DEPTH); transitions only by push (+1), pop (-1), or both (0).
REQ-028 fwd_hit SHALL be combinational: 1 iff any valid buffered entry has rd == fwd_rs; fwd_data SHALL be the youngest matching entry's data, 0 when no hit.
REQ-029 The entry being popped in the current cycle SHALL still count as a hit that cycle.

Reset
REQ-030 With rst=1 at a clock edge: count, pointers, apsr_flags SHALL become 0; wb_valid, fwd_hit SHALL be 0 the following cycle.
REQ-031 Reset mid-operation SHALL discard all buffered entries; no wb_valid pulse for discarded entries after reset.
REQ-032 Accept and pop during the reset cycle SHALL be ignored.

Configuration
REQ-033 Macro EXEC_WB_FORWARD_EN: when defined, forwarding per REQ-028/029 is built.
REQ-034 When EXEC_WB_FORWARD_EN is undefined, fwd_hit and fwd_data SHALL be constant 0 and no comparators are instantiated; all other behaviour unchanged.

Verification
REQ-035 Reset, then push rd=3 data=0x0000_00AA, wb_ready=1 -> next cycle wb_valid=1, wb_rd=3, wb_data=0xAA; following cycle wb_valid=0.
REQ-036 wb_ready=0, push rd=1 0x11 then rd=2 0x22 (DEPTH=2) -> in_ready=0; third in_valid held until wb_ready=1, then pops in order 0x11, 0x22, then third value.
REQ-037 Accept in_wr_rd=0, in_set_flags=1, in_flags=4'b0110 -> apsr_flags=4'b0110 next cycle, wb_valid stays 0.
REQ-038 Buffer rd=5 0x10 then rd=5 0x20, fwd_rs=5 -> fwd_hit=1, fwd_data=0x20 (macro on); macro off -> fwd_hit=0, fwd_data=0.
REQ-039 Full buffer with apsr_flags=4'b1000, assert rst one cycle -> wb_valid=0, apsr_flags=0, in_ready=1 next cycle; no stale writes later.
REQ-040 Count=1 with simultaneous push and pop for 8 cycles (data 1..8) -> count stays 1, pops emit values in push order across pointer wrap.
